// File: rtl/rr_arb_mux_if.sv
// Valid/ready bundle between M producers, the round-robin arbiter and one consumer.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface rr_arb_mux_if #(
  parameter int N = 32,
  parameter int M = 8
);
  localparam int S = $clog2(M);

  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// M-channel valid/ready round-robin arbiter feeding a single registered output slot.
// Define RR_ARB_MUX_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module rr_arb_mux #(
  parameter int N = 32,
  parameter int M = 8
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int S = $clog2(M);

  logic [S-1:0] ptr;
  logic [M-1:0] grant;
  logic [S-1:0] grant_idx;
  logic [N-1:0] grant_data;
  logic         grant_found;
  logic         open;
  logic         transfer;
  int           cand;

  // The slot can take a word when empty or when the held word leaves this cycle.
  assign open = !bus.out_valid || bus.out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    grant       = '0;
    grant_idx   = '0;
    grant_data  = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int k = 0; k < M; k++) begin
      // Explicit wrap keeps the search inside 0..M-1 for non-power-of-two M.
      cand = int'(ptr) + k;
      if (cand >= M) cand = cand - M;
      if (!grant_found && bus.in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = S'(cand);
        grant_data  = bus.in_data[cand*N +: N];
      end
    end
    if (!rst && open && grant_found) grant[grant_idx] = 1'b1;
  end

  assign bus.in_ready = grant;
  assign transfer     = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else if (transfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= grant_data;
      bus.out_sel   <= grant_idx;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (grant_idx == S'(M - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus a randomized run against a
// queue-free reference model of the arbitration rules (M=8), and a wrap check with M=5.
module tb_rr_arb_mux;
  localparam int N = 32;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arb_mux_if #(.N(N), .M(8)) bus8 ();
  rr_arb_mux_if #(.N(N), .M(5)) bus5 ();

  rr_arb_mux #(.N(N), .M(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  rr_arb_mux #(.N(N), .M(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requesting channel found scanning p, p+1, ... modulo m.
  function automatic int pick(logic [7:0] v, int p, int m);
    for (int k = 0; k < m; k++) begin
      if (v[(p + k) % m]) return (p + k) % m;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    bus8.in_valid  = '0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;
    bus5.in_valid  = '0;
    bus5.in_data   = '0;
    bus5.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus8.in_ready !== 8'h00 || bus8.out_valid !== 1'b0 || bus8.out_data !== 32'h0 || bus8.out_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_init: got ready=%h valid=%b data=%h sel=%0d, want 00/0/0/0",
               bus8.in_ready, bus8.out_valid, bus8.out_data, bus8.out_sel);
    end
    // Load ch3 (pointer moves to 4), hold it with backpressure, then reset mid-cycle.
    @(negedge clk);
    rst = 1'b0;
    bus8.in_valid = 8'b0000_1000;
    bus8.in_data[3*N +: N] = 32'h3333_3333;
    bus8.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 8'b1000_1001;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_sel !== 3'd3) begin
      errors++;
      $display("FAIL reset_preload: got valid=%b sel=%0d, want 1/3", bus8.out_valid, bus8.out_sel);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 8'h00 || bus8.out_valid !== 1'b0 || bus8.out_data !== 32'h0 || bus8.out_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: got ready=%h valid=%b data=%h sel=%0d, want 00/0/0/0",
               bus8.in_ready, bus8.out_valid, bus8.out_data, bus8.out_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus8.in_ready !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_first_grant: got ready=%b, want 00000001", bus8.in_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    bus8.in_valid = 8'b0010_0000;
    bus8.in_data[5*N +: N] = 32'hDEAD_BEEF;
    bus8.out_ready = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 8'b0010_0000) begin
      errors++;
      $display("FAIL single_ready: got %b, want 00100000", bus8.in_ready);
    end
    @(posedge clk);
    #1;
    bus8.in_valid = '0;
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_data !== 32'hDEAD_BEEF || bus8.out_sel !== 3'd5) begin
      errors++;
      $display("FAIL single_out: got valid=%b data=%h sel=%0d, want 1/deadbeef/5",
               bus8.out_valid, bus8.out_data, bus8.out_sel);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) bus8.in_data[i*N +: N] = 32'(i);
    for (int i = 0; i < 5; i++) bus5.in_data[i*N +: N] = 32'(i);
    bus8.in_valid = '1;
    bus5.in_valid = '1;
    bus8.out_ready = 1'b1;
    bus5.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.out_sel !== 3'(k % 8) || bus8.out_data !== 32'(k % 8)) begin
        errors++;
        $display("FAIL rr_m8[%0d]: got valid=%b sel=%0d data=%h, want 1/%0d/%0d",
                 k, bus8.out_valid, bus8.out_sel, bus8.out_data, k % 8, k % 8);
      end
      checks++;
      if (bus5.out_valid !== 1'b1 || bus5.out_sel !== 3'(k % 5) || bus5.out_data !== 32'(k % 5)) begin
        errors++;
        $display("FAIL rr_m5[%0d]: got valid=%b sel=%0d data=%h, want 1/%0d/%0d",
                 k, bus5.out_valid, bus5.out_sel, bus5.out_data, k % 5, k % 5);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) bus8.in_data[i*N +: N] = 32'hC0DE_0000 + 32'(i);
    bus8.in_valid = '1;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus8.in_ready !== 8'h00) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b, want 00000000", k, bus8.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.out_sel !== 3'd0 || bus8.out_data !== 32'hC0DE_0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b sel=%0d data=%h, want 1/0/c0de0000",
                 k, bus8.out_valid, bus8.out_sel, bus8.out_data);
      end
      @(negedge clk);
    end
    bus8.out_ready = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 8'b0000_0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, want 00000010", bus8.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_sel !== 3'd1 || bus8.out_data !== 32'hC0DE_0001) begin
      errors++;
      $display("FAIL bp_release_out: got valid=%b sel=%0d data=%h, want 1/1/c0de0001",
               bus8.out_valid, bus8.out_sel, bus8.out_data);
    end
  endtask

  task automatic test_drain();
    do_reset();
    @(negedge clk);
    bus8.in_valid = 8'b0000_0100;
    bus8.in_data[2*N +: N] = 32'h2222_ABCD;
    bus8.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = '0;
    bus8.out_ready = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 8'h00 || bus8.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_pre: got ready=%b valid=%b, want 00000000/1", bus8.in_ready, bus8.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.out_data !== 32'h2222_ABCD || bus8.out_sel !== 3'd2) begin
      errors++;
      $display("FAIL drain_out: got valid=%b data=%h sel=%0d, want 0/2222abcd/2",
               bus8.out_valid, bus8.out_data, bus8.out_sel);
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    @(negedge clk);
    bus8.in_data[1*N +: N] = 32'h1111_0001;
    bus8.in_data[6*N +: N] = 32'h6666_0006;
    bus8.in_valid = 8'b0100_0010;
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.out_sel !== 3'd1) begin
        errors++;
        $display("FAIL fixed_ch1[%0d]: got valid=%b sel=%0d, want 1/1", k, bus8.out_valid, bus8.out_sel);
      end
    end
    @(negedge clk);
    bus8.in_valid = 8'b0100_0000;
    @(posedge clk);
    #1;
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_sel !== 3'd6 || bus8.out_data !== 32'h6666_0006) begin
      errors++;
      $display("FAIL fixed_ch6: got valid=%b sel=%0d data=%h, want 1/6/66660006",
               bus8.out_valid, bus8.out_sel, bus8.out_data);
    end
  endtask

  // Random producers hold each request until accepted; the model tracks the output slot and pointer.
  task automatic test_random();
    logic [7:0]  pend;
    logic [31:0] dat [8];
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_ptr;
    int          g;
    bit          open;
    logic [7:0]  exp_ready;
    do_reset();
    pend = '0;
    m_valid = 1'b0;
    m_data = '0;
    m_sel = 0;
    m_ptr = 0;
    for (int i = 0; i < 8; i++) dat[i] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          dat[i] = $urandom;
        end
        bus8.in_data[i*N +: N] = dat[i];
      end
      bus8.in_valid = pend;
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      open = !m_valid || bus8.out_ready;
      g = open ? pick(pend, FIXED ? 0 : m_ptr, 8) : -1;
      exp_ready = (g >= 0) ? (8'b1 << g) : 8'b0;
      checks++;
      if (bus8.in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b, want %b", cyc, bus8.in_ready, exp_ready);
      end
      checks++;
      if (bus8.out_valid !== m_valid || (m_valid && (bus8.out_data !== m_data || bus8.out_sel !== 3'(m_sel)))) begin
        errors++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h sel=%0d, want %b/%h/%0d",
                 cyc, bus8.out_valid, bus8.out_data, bus8.out_sel, m_valid, m_data, m_sel);
      end
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data = dat[g];
        m_sel = g;
        m_ptr = (g + 1) % 8;
        pend[g] = 1'b0;
      end else if (m_valid && bus8.out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
    test_round_robin();
    test_backpressure();
`else
    test_fixed_prio();
`endif
    test_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
